// File: rtl/issue_scoreboard.sv
// In-order issue / out-of-order writeback / in-order commit scoreboard.
// Optional result forwarding to issue hazard lookups is enabled by defining SB_FORWARD_EN.
module issue_scoreboard #(
  parameter int unsigned NR_ENTRIES = 8,
  parameter int unsigned NR_WB_PORTS = 4,
  localparam int unsigned TRANS_ID_BITS = $clog2(NR_ENTRIES)
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   flush_i,
  input  logic                                   issue_valid_i,
  output logic                                   issue_ready_o,
  input  logic [63:0]                            issue_pc_i,
  input  logic [4:0]                             issue_rd_i,
  output logic [TRANS_ID_BITS-1:0]               issue_trans_id_o,
  input  logic [NR_WB_PORTS-1:0]                 wb_valid_i,
  input  logic [NR_WB_PORTS*TRANS_ID_BITS-1:0]   wb_trans_id_i,
  input  logic [NR_WB_PORTS*64-1:0]              wb_data_i,
  input  logic [NR_WB_PORTS-1:0]                 wb_ex_valid_i,
  output logic                                   commit_valid_o,
  input  logic                                   commit_ack_i,
  output logic [63:0]                            commit_pc_o,
  output logic [4:0]                             commit_rd_o,
  output logic [63:0]                            commit_result_o,
  output logic                                   commit_ex_o,
  input  logic [4:0]                             rs1_i,
  input  logic [4:0]                             rs2_i,
  output logic                                   rs1_busy_o,
  output logic                                   rs2_busy_o,
  output logic                                   rs1_fwd_valid_o,
  output logic                                   rs2_fwd_valid_o,
  output logic [63:0]                            rs1_fwd_o,
  output logic [63:0]                            rs2_fwd_o
);

  localparam int unsigned CNT_BITS = TRANS_ID_BITS + 1;

  logic [63:0]              pc_q     [NR_ENTRIES];
  logic [63:0]              pc_d     [NR_ENTRIES];
  logic [4:0]               rd_q     [NR_ENTRIES];
  logic [4:0]               rd_d     [NR_ENTRIES];
  logic [63:0]              result_q [NR_ENTRIES];
  logic [63:0]              result_d [NR_ENTRIES];
  logic [NR_ENTRIES-1:0]    valid_q, valid_d;
  logic [NR_ENTRIES-1:0]    ex_q, ex_d;
  logic [TRANS_ID_BITS-1:0] issue_ptr_q, issue_ptr_d;
  logic [TRANS_ID_BITS-1:0] commit_ptr_q, commit_ptr_d;
  logic [CNT_BITS-1:0]      count_q, count_d;

  logic [NR_ENTRIES-1:0]    occ_c;
  logic                     do_issue, do_commit;

  assign issue_ready_o    = (count_q != CNT_BITS'(NR_ENTRIES));
  assign issue_trans_id_o = issue_ptr_q;
  assign commit_valid_o   = (count_q != '0) && valid_q[commit_ptr_q];
  assign commit_pc_o      = pc_q[commit_ptr_q];
  assign commit_rd_o      = rd_q[commit_ptr_q];
  assign commit_result_o  = result_q[commit_ptr_q];
  assign commit_ex_o      = ex_q[commit_ptr_q];
  assign do_issue         = issue_valid_i && issue_ready_o;
  assign do_commit        = commit_ack_i && commit_valid_o;

  // A slot is occupied when its distance from commit_ptr is below the count.
  always_comb begin
    logic [TRANS_ID_BITS-1:0] off;
    occ_c = '0;
    for (int unsigned i = 0; i < NR_ENTRIES; i++) begin
      off      = TRANS_ID_BITS'(i) - commit_ptr_q;
      occ_c[i] = (CNT_BITS'(off) < count_q);
    end
  end

  // Next-state: issue write, writebacks (higher port wins), commit clears last, flush dominates.
  always_comb begin
    logic [TRANS_ID_BITS-1:0] id;
    pc_d         = pc_q;
    rd_d         = rd_q;
    result_d     = result_q;
    valid_d      = valid_q;
    ex_d         = ex_q;
    issue_ptr_d  = issue_ptr_q;
    commit_ptr_d = commit_ptr_q;
    count_d      = count_q;
    id           = '0;
    if (do_issue) begin
      pc_d[issue_ptr_q]    = issue_pc_i;
      rd_d[issue_ptr_q]    = issue_rd_i;
      valid_d[issue_ptr_q] = 1'b0;
      ex_d[issue_ptr_q]    = 1'b0;
      issue_ptr_d          = issue_ptr_q + TRANS_ID_BITS'(1);
    end
    for (int unsigned k = 0; k < NR_WB_PORTS; k++) begin
      id = wb_trans_id_i[k*TRANS_ID_BITS +: TRANS_ID_BITS];
      if (wb_valid_i[k] && occ_c[id]) begin
        result_d[id] = wb_data_i[k*64 +: 64];
        valid_d[id]  = 1'b1;
        ex_d[id]     = wb_ex_valid_i[k];
      end
    end
    if (do_commit) begin
      valid_d[commit_ptr_q] = 1'b0;
      ex_d[commit_ptr_q]    = 1'b0;
      commit_ptr_d          = commit_ptr_q + TRANS_ID_BITS'(1);
    end
    if (do_issue && !do_commit) count_d = count_q + CNT_BITS'(1);
    else if (!do_issue && do_commit) count_d = count_q - CNT_BITS'(1);
    if (flush_i) begin
      valid_d      = '0;
      ex_d         = '0;
      issue_ptr_d  = '0;
      commit_ptr_d = '0;
      count_d      = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NR_ENTRIES; i++) begin
        pc_q[i]     <= '0;
        rd_q[i]     <= '0;
        result_q[i] <= '0;
      end
      valid_q      <= '0;
      ex_q         <= '0;
      issue_ptr_q  <= '0;
      commit_ptr_q <= '0;
      count_q      <= '0;
    end else begin
      pc_q         <= pc_d;
      rd_q         <= rd_d;
      result_q     <= result_d;
      valid_q      <= valid_d;
      ex_q         <= ex_d;
      issue_ptr_q  <= issue_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      count_q      <= count_d;
    end
  end

  // Register-busy lookup over occupied entries; x0 is never busy.
  always_comb begin
    rs1_busy_o = 1'b0;
    rs2_busy_o = 1'b0;
    for (int unsigned i = 0; i < NR_ENTRIES; i++) begin
      if (occ_c[i] && rd_q[i] == rs1_i && rs1_i != 5'd0) rs1_busy_o = 1'b1;
      if (occ_c[i] && rd_q[i] == rs2_i && rs2_i != 5'd0) rs2_busy_o = 1'b1;
    end
  end

`ifdef SB_FORWARD_EN
  // Walk oldest to youngest so the last match is the youngest writer.
  always_comb begin
    logic [TRANS_ID_BITS-1:0] idx;
    logic [TRANS_ID_BITS-1:0] rs1_idx, rs2_idx;
    logic                     rs1_hit, rs2_hit;
    idx     = '0;
    rs1_idx = '0;
    rs2_idx = '0;
    rs1_hit = 1'b0;
    rs2_hit = 1'b0;
    for (int unsigned j = 0; j < NR_ENTRIES; j++) begin
      idx = commit_ptr_q + TRANS_ID_BITS'(j);
      if (CNT_BITS'(j) < count_q) begin
        if (rd_q[idx] == rs1_i) begin
          rs1_hit = 1'b1;
          rs1_idx = idx;
        end
        if (rd_q[idx] == rs2_i) begin
          rs2_hit = 1'b1;
          rs2_idx = idx;
        end
      end
    end
    rs1_fwd_valid_o = rs1_hit && (rs1_i != 5'd0) && valid_q[rs1_idx] && !ex_q[rs1_idx];
    rs2_fwd_valid_o = rs2_hit && (rs2_i != 5'd0) && valid_q[rs2_idx] && !ex_q[rs2_idx];
    rs1_fwd_o       = rs1_fwd_valid_o ? result_q[rs1_idx] : 64'd0;
    rs2_fwd_o       = rs2_fwd_valid_o ? result_q[rs2_idx] : 64'd0;
  end
`else
  assign rs1_fwd_valid_o = 1'b0;
  assign rs2_fwd_valid_o = 1'b0;
  assign rs1_fwd_o       = 64'd0;
  assign rs2_fwd_o       = 64'd0;
`endif

endmodule
